// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants for the branch target buffer: direction-counter encodings
// and default geometry.
package branch_predictor_btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int BTB_DEF_ADDR_W  = 16;
    localparam int BTB_DEF_ENTRIES = 16;
    localparam int BTB_DEF_CNT_W   = 16;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup and EX-resolve bundle between the pipeline (master) and the BTB (slave).
interface branch_predictor_btb_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              bp_flush;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_pc;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_is_branch;
    logic              ex_uncond;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_pc;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  mp_count;

    modport master (
        output bp_flush, if_pc, ex_valid, ex_pc, ex_is_branch, ex_uncond,
               ex_taken, ex_target, ex_pred_taken, ex_pred_pc,
        input  pred_hit, pred_taken, pred_pc, mispredict, redirect_pc,
               br_count, mp_count
    );

    modport slave (
        input  bp_flush, if_pc, ex_valid, ex_pc, ex_is_branch, ex_uncond,
               ex_taken, ex_target, ex_pred_taken, ex_pred_pc,
        output pred_hit, pred_taken, pred_pc, mispredict, redirect_pc,
               br_count, mp_count
    );
endinterface

// File: rtl/branch_predictor_btb_sat_ctr.sv
// 2-bit saturating up/down direction counter for one BTB entry; clear wins over
// load, load (fresh allocation) wins over count.
module bp_sat_ctr
    import branch_predictor_btb_pkg::*;
#(
    parameter logic [1:0] INIT = CTR_WNT
) (
    input  logic       clk,
    input  logic       pc_reset,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       en_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    logic [1:0] ctr_q, ctr_d;

    // NOTE: every signal written in always_comb gets a default first, otherwise
    // the paths that skip an assignment infer a latch.
    always_comb begin
        ctr_d = ctr_q;
        if (clr_i) begin
            ctr_d = INIT;
        end else if (load_i) begin
            ctr_d = CTR_WT;
        end else if (en_i) begin
            if (up_i && ctr_q != CTR_ST) begin
                ctr_d = ctr_q + 2'd1;
            end else if (!up_i && ctr_q != CTR_SNT) begin
                ctr_d = ctr_q - 2'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            ctr_q <= INIT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters,
// EX-stage mispredict detection and saturating branch/mispredict statistics.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int         ADDR_W   = BTB_DEF_ADDR_W,
    parameter int         ENTRIES  = BTB_DEF_ENTRIES,
    parameter logic [1:0] CTR_INIT = CTR_WNT,
    parameter int         CNT_W    = BTB_DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   pc_reset,
    branch_predictor_btb_if.slave  bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic               uncond_q [ENTRIES];
    logic [1:0]         ctr      [ENTRIES];

    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;

    // ---------------- IF lookup (asynchronous read, pre-edge contents) ----------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bp.if_pc[IDX_W-1:0];
    assign lk_tag   = bp.if_pc[ADDR_W-1:IDX_W];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && (uncond_q[lk_idx] || ctr[lk_idx][1]);

    assign bp.pred_hit   = lk_hit;
    assign bp.pred_taken = lk_taken;
    assign bp.pred_pc    = lk_taken ? target_q[lk_idx] : bp.if_pc + ADDR_W'(1);

    // ---------------- EX resolve ----------------
    logic [ADDR_W-1:0] cpc;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic              upd_en;
    logic              upd_hit_br;
    logic              upd_alloc;
    logic              upd_kill;

    assign cpc           = bp.ex_taken ? bp.ex_target : bp.ex_pc + ADDR_W'(1);
    assign bp.mispredict  = bp.ex_valid && (bp.ex_pred_pc != cpc);
    assign bp.redirect_pc = cpc;

    assign ex_idx = bp.ex_pc[IDX_W-1:0];
    assign ex_tag = bp.ex_pc[ADDR_W-1:IDX_W];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // A flush in the same cycle discards the table update but not the statistics.
    assign upd_en     = bp.ex_valid && !bp.bp_flush;
    assign upd_hit_br = upd_en && bp.ex_is_branch && ex_hit;
    assign upd_alloc  = upd_en && bp.ex_is_branch && !ex_hit && bp.ex_taken;
    assign upd_kill   = upd_en && !bp.ex_is_branch && ex_hit;

    always_comb begin
        valid_d = valid_q;
        if (bp.bp_flush) begin
            valid_d = '0;
        end else if (upd_alloc) begin
            valid_d[ex_idx] = 1'b1;
        end else if (upd_kill) begin
            valid_d[ex_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload arrays are deliberately not reset; valid gates every use,
    // so a reset network on the whole table would buy nothing.
    always_ff @(posedge clk) begin
        if (upd_alloc) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= bp.ex_target;
            uncond_q[ex_idx] <= bp.ex_uncond;
        end else if (upd_hit_br) begin
            uncond_q[ex_idx] <= bp.ex_uncond;
            if (bp.ex_taken) begin
                target_q[ex_idx] <= bp.ex_target;
            end
        end
    end

    // One direction counter per entry.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_ctr #(
            .INIT (CTR_INIT)
        ) u_ctr (
            .clk      (clk),
            .pc_reset (pc_reset),
            .clr_i    (bp.bp_flush),
            .load_i   (upd_alloc && (ex_idx == IDX_W'(i))),
            .en_i     (upd_hit_br && (ex_idx == IDX_W'(i))),
            .up_i     (bp.ex_taken),
            .ctr_o    (ctr[i])
        );
    end

    // ---------------- statistics ----------------
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (bp.ex_valid && bp.ex_is_branch && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (bp.mispredict && mp_cnt_q != '1) begin
            mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign bp.br_count = br_cnt_q;
    assign bp.mp_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a default instance for table behaviour
// and a CNT_W=4 instance for statistics saturation.
module tb_branch_predictor_btb;

    logic clk;
    logic pc_reset;
    int   n_cmp;
    int   n_err;

    branch_predictor_btb_if #(.ADDR_W(16), .CNT_W(16)) bp_a ();
    branch_predictor_btb_if #(.ADDR_W(16), .CNT_W(4))  bp_b ();

    branch_predictor_btb #(
        .ADDR_W (16), .ENTRIES (16), .CTR_INIT (2'b01), .CNT_W (16)
    ) u_dut (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bp       (bp_a)
    );

    branch_predictor_btb #(
        .ADDR_W (16), .ENTRIES (16), .CTR_INIT (2'b01), .CNT_W (4)
    ) u_dut_sat (
        .clk      (clk),
        .pc_reset (pc_reset),
        .bp       (bp_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [15:0] pc);
        bp_a.if_pc = pc;
        #1;
    endtask

    task automatic drive_ex(input logic br, input logic unc, input logic tk,
                            input logic [15:0] pc, input logic [15:0] tgt,
                            input logic [15:0] ppc);
        bp_a.ex_valid      = 1'b1;
        bp_a.ex_is_branch  = br;
        bp_a.ex_uncond     = unc;
        bp_a.ex_taken      = tk;
        bp_a.ex_pc         = pc;
        bp_a.ex_target     = tgt;
        bp_a.ex_pred_pc    = ppc;
        bp_a.ex_pred_taken = (ppc != pc + 16'd1);
        #1;
    endtask

    task automatic idle_ex();
        bp_a.ex_valid     = 1'b0;
        bp_a.ex_is_branch = 1'b0;
        bp_a.ex_uncond    = 1'b0;
        bp_a.ex_taken     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pc_reset = 1'b1;
        bp_a.bp_flush = 1'b0; bp_a.if_pc = 16'h0; bp_a.ex_pc = 16'h0;
        bp_a.ex_target = 16'h0; bp_a.ex_pred_pc = 16'h0; bp_a.ex_pred_taken = 1'b0;
        idle_ex();
        bp_b.bp_flush = 1'b0; bp_b.if_pc = 16'h0; bp_b.ex_valid = 1'b0;
        bp_b.ex_pc = 16'h0; bp_b.ex_is_branch = 1'b0; bp_b.ex_uncond = 1'b0;
        bp_b.ex_taken = 1'b0; bp_b.ex_target = 16'h0; bp_b.ex_pred_taken = 1'b0;
        bp_b.ex_pred_pc = 16'h0;
        #12 pc_reset = 1'b0;

        // Reset state
        look(16'h0010);
        check("rst_hit",   32'(bp_a.pred_hit),   32'h0);
        check("rst_taken", 32'(bp_a.pred_taken), 32'h0);
        check("rst_ppc",   32'(bp_a.pred_pc),    32'h0011);
        check("rst_br",    32'(bp_a.br_count),   32'h0);
        check("rst_mp",    32'(bp_a.mp_count),   32'h0);

        // Taken beq at 0x10 -> 0x40, predicted fall-through: allocate, ctr=10
        drive_ex(1, 0, 1, 16'h0010, 16'h0040, 16'h0011);
        check("alloc_mp",     32'(bp_a.mispredict),  32'h1);
        check("alloc_redir",  32'(bp_a.redirect_pc), 32'h0040);
        check("same_cyc_hit", 32'(bp_a.pred_hit),    32'h0);
        tick(); idle_ex(); #1;
        check("alloc_hit",   32'(bp_a.pred_hit),   32'h1);
        check("alloc_taken", 32'(bp_a.pred_taken), 32'h1);
        check("alloc_ppc",   32'(bp_a.pred_pc),    32'h0040);
        check("alloc_br",    32'(bp_a.br_count),   32'h1);
        check("alloc_mpc",   32'(bp_a.mp_count),   32'h1);

        // Not taken, predicted taken: ctr 10 -> 01
        drive_ex(1, 0, 0, 16'h0010, 16'h0040, 16'h0040);
        check("nt1_mp", 32'(bp_a.mispredict), 32'h1);
        check("nt1_redir", 32'(bp_a.redirect_pc), 32'h0011);
        tick(); idle_ex(); #1;
        check("nt1_hit",   32'(bp_a.pred_hit),   32'h1);
        check("nt1_taken", 32'(bp_a.pred_taken), 32'h0);
        check("nt1_ppc",   32'(bp_a.pred_pc),    32'h0011);
        // Not taken, predicted not taken: 01 -> 00, then 00 holds
        drive_ex(1, 0, 0, 16'h0010, 16'h0040, 16'h0011);
        check("nt2_mp", 32'(bp_a.mispredict), 32'h0);
        tick();
        drive_ex(1, 0, 0, 16'h0010, 16'h0040, 16'h0011);
        tick(); idle_ex(); #1;
        check("nt3_br", 32'(bp_a.br_count), 32'h4);
        check("nt3_mp", 32'(bp_a.mp_count), 32'h2);
        // One taken: 00 -> 01 still not taken (a wrapped 11 would predict taken)
        drive_ex(1, 0, 1, 16'h0010, 16'h0040, 16'h0011);
        tick(); idle_ex(); #1;
        check("sat0_taken", 32'(bp_a.pred_taken), 32'h0);
        drive_ex(1, 0, 1, 16'h0010, 16'h0040, 16'h0011);
        tick(); idle_ex(); #1;
        check("up_taken", 32'(bp_a.pred_taken), 32'h1);
        check("up_br",    32'(bp_a.br_count),   32'h6);
        check("up_mp",    32'(bp_a.mp_count),   32'h4);

        // Alias: 0x110 shares index 0 with a different tag
        look(16'h0110);
        check("alias_miss", 32'(bp_a.pred_hit), 32'h0);
        drive_ex(0, 0, 0, 16'h0110, 16'h0000, 16'h0111);
        check("alias_nb_mp", 32'(bp_a.mispredict), 32'h0);
        tick(); idle_ex();
        look(16'h0010);
        check("alias_keep", 32'(bp_a.pred_hit), 32'h1);
        drive_ex(1, 0, 1, 16'h0110, 16'h0200, 16'h0111);
        tick(); idle_ex();
        look(16'h0110);
        check("repl_hit", 32'(bp_a.pred_hit), 32'h1);
        check("repl_ppc", 32'(bp_a.pred_pc),  32'h0200);
        look(16'h0010);
        check("repl_old_miss", 32'(bp_a.pred_hit), 32'h0);
        drive_ex(0, 0, 0, 16'h0110, 16'h0000, 16'h0200);
        check("kill_mp",    32'(bp_a.mispredict),  32'h1);
        check("kill_redir", 32'(bp_a.redirect_pc), 32'h0111);
        tick(); idle_ex();
        look(16'h0110);
        check("kill_miss", 32'(bp_a.pred_hit), 32'h0);
        check("kill_ppc",  32'(bp_a.pred_pc),  32'h0111);
        check("kill_br",   32'(bp_a.br_count), 32'h7);
        check("kill_mpc",  32'(bp_a.mp_count), 32'h6);

        // br with a changed register target
        drive_ex(1, 1, 1, 16'h0010, 16'h0040, 16'h0011);
        tick(); idle_ex();
        look(16'h0010);
        check("br_ppc0", 32'(bp_a.pred_pc), 32'h0040);
        drive_ex(1, 1, 1, 16'h0010, 16'h0080, 16'h0040);
        check("br_mp",    32'(bp_a.mispredict),  32'h1);
        check("br_redir", 32'(bp_a.redirect_pc), 32'h0080);
        tick(); idle_ex();
        look(16'h0010);
        check("br_ppc1", 32'(bp_a.pred_pc), 32'h0080);
        check("br_br",   32'(bp_a.br_count), 32'h9);
        check("br_mpc",  32'(bp_a.mp_count), 32'h8);

        // PC wrap on a miss
        look(16'hFFFF);
        check("wrap_ppc", 32'(bp_a.pred_pc), 32'h0000);

        // Flush with a coincident allocating update
        bp_a.bp_flush = 1'b1;
        drive_ex(1, 0, 1, 16'h0025, 16'h0300, 16'h0026);
        tick(); idle_ex(); bp_a.bp_flush = 1'b0;
        look(16'h0010);
        check("flush_miss0", 32'(bp_a.pred_hit), 32'h0);
        look(16'h0025);
        check("flush_miss1", 32'(bp_a.pred_hit), 32'h0);
        check("flush_br",    32'(bp_a.br_count), 32'hA);
        check("flush_mpc",   32'(bp_a.mp_count), 32'h9);

        // Asynchronous reset mid-run, with an update pending across the edge
        drive_ex(1, 0, 1, 16'h0010, 16'h0040, 16'h0011);
        tick();
        drive_ex(1, 0, 1, 16'h0030, 16'h0050, 16'h0031);
        look(16'h0010);
        check("pre_rst_hit", 32'(bp_a.pred_hit), 32'h1);
        pc_reset = 1'b1;
        #1;
        check("arst_hit", 32'(bp_a.pred_hit), 32'h0);
        check("arst_br",  32'(bp_a.br_count), 32'h0);
        check("arst_mp",  32'(bp_a.mp_count), 32'h0);
        tick();
        pc_reset = 1'b0; idle_ex();
        look(16'h0030);
        check("arst_upd_drop", 32'(bp_a.pred_hit), 32'h0);
        check("arst_br2",      32'(bp_a.br_count), 32'h0);

        // Saturation on the CNT_W=4 instance: every cycle a mispredicted branch
        bp_b.ex_valid = 1'b1; bp_b.ex_is_branch = 1'b1; bp_b.ex_taken = 1'b0;
        bp_b.ex_pc = 16'h0003; bp_b.ex_pred_pc = 16'h0003;
        for (int i = 0; i < 14; i++) tick();
        check("sat_br_e", 32'(bp_b.br_count), 32'hE);
        check("sat_mp_e", 32'(bp_b.mp_count), 32'hE);
        tick();
        check("sat_br_f", 32'(bp_b.br_count), 32'hF);
        for (int i = 0; i < 3; i++) tick();
        check("sat_br_hold", 32'(bp_b.br_count), 32'hF);
        check("sat_mp_hold", 32'(bp_b.mp_count), 32'hF);
        bp_b.ex_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
